// File: rtl/column_sync_ctrl_pkg.sv
// Shared definitions for the column sweep controller: state codes, node fixed-point
// format and RGB332 field layout.
package column_sync_ctrl_pkg;

  localparam int FX_W    = 32;
  localparam int FX_FRAC = 27;
  // Heat level is taken from the top three integer bits of the magnitude.
  localparam int LVL_LSB = FX_FRAC + 1;

  localparam int RGB_R_LSB = 5;
  localparam int RGB_R_W   = 3;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_G_W   = 3;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_B_W   = 2;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_INIT_WAIT  = 3'd1;
  localparam logic [2:0] ST_START      = 3'd2;
  localparam logic [2:0] ST_CLEAR      = 3'd3;
  localparam logic [2:0] ST_WAIT_FLAGS = 3'd4;
  localparam logic [2:0] ST_CAPTURE    = 3'd5;
  localparam logic [2:0] ST_NEXT       = 3'd6;
  localparam logic [2:0] ST_DONE       = 3'd7;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } pix_addr_t;

  // |v| with the most negative code clamped to the largest positive code.
  function automatic logic [FX_W-1:0] sat_abs(input logic [FX_W-1:0] v);
    logic [FX_W-1:0] n;
    n = ~v + 1'b1;
    if (!v[FX_W-1])
      return v;
    else if (n[FX_W-1])
      return {1'b0, {(FX_W-1){1'b1}}};
    else
      return n;
  endfunction

endpackage

// File: rtl/column_sync_ctrl_if.sv
// Column and pixel-sink bus of the sweep controller; master is the controller side.
interface column_sync_ctrl_if import column_sync_ctrl_pkg::*; #(
  parameter int NUM_COLS = 8
);
  logic                     start;
  logic [NUM_COLS-1:0]      init_vec;
  logic [NUM_COLS-1:0]      flag_vec;
  logic [FX_W*NUM_COLS-1:0] node_center_bus;
  logic                     pix_we;
  logic                     pix_ready;
  logic [15:0]              pix_addr;
  logic [7:0]               pix_data;

  modport master (
    output start, pix_we, pix_addr, pix_data,
    input  init_vec, flag_vec, node_center_bus, pix_ready
  );

  modport slave (
    input  start, pix_we, pix_addr, pix_data,
    output init_vec, flag_vec, node_center_bus, pix_ready
  );
endinterface

// File: rtl/heat_color_map.sv
// Signed 1.4.27 node value to RGB332: positive values shade red, negative shade blue.
module heat_color_map import column_sync_ctrl_pkg::*; (
  input  logic [FX_W-1:0] value,
  output logic [7:0]      color
);
  logic [FX_W-1:0] mag;
  logic [2:0]      lvl;

  assign mag = sat_abs(value);
  assign lvl = mag[LVL_LSB +: 3];

  // A non-zero level implies a non-zero value, so the sign bit alone picks the hue.
  always_comb begin
    color = '0;
    if (lvl != 3'd0) begin
      if (!value[FX_W-1])
        color[RGB_R_LSB +: RGB_R_W] = lvl;
      else
        color[RGB_B_LSB +: RGB_B_W] = lvl[2:1];
    end
  end
endmodule

// File: rtl/column_sync_ctrl.sv
// Lock-step row sweep over NUM_COLS build_column instances, with optional per-row
// pixel capture of the column node values into a frame buffer.
module column_sync_ctrl import column_sync_ctrl_pkg::*; #(
  parameter int NUM_COLS = 8,
  parameter int ITER_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [7:0]             height,
  input  logic [ITER_W-1:0]      iter_limit,
  input  logic                   capture_en,
  column_sync_ctrl_if.master     cb,
  output logic [7:0]             row_idx,
  output logic [ITER_W-1:0]      sweep_count,
  output logic                   busy,
  output logic                   sweep_done
);
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  logic [2:0]                     state;
  logic [COL_W-1:0]               col;
  logic [NUM_COLS-1:0][FX_W-1:0]  snap;
  logic [FX_W-1:0]                sel_word;
  logic [7:0]                     color;
  logic                           wrap;
  logic                           last_col;
  logic [ITER_W-1:0]              next_count;
  pix_addr_t                      addr;

  assign wrap       = (row_idx == height);
  assign next_count = sweep_count + {{(ITER_W-1){1'b0}}, wrap};
  assign last_col   = (col == COL_W'(NUM_COLS-1));
  assign sel_word   = snap[col];

  heat_color_map u_cmap (
    .value (sel_word),
    .color (color)
  );

  assign addr.row    = row_idx;
  assign addr.col    = 8'(col);
  assign cb.start    = (state == ST_START);
  assign cb.pix_we   = (state == ST_CAPTURE);
  assign cb.pix_addr = addr;
  assign cb.pix_data = color;
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      col         <= '0;
      snap        <= '0;
      row_idx     <= '0;
      sweep_count <= '0;
      sweep_done  <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        ST_IDLE:       if (run) state <= ST_INIT_WAIT;
        ST_INIT_WAIT:  if (&cb.init_vec) state <= ST_START;
        ST_START:      state <= ST_CLEAR;
        // Columns drop their done flags on the start edge; skipping one cycle
        // keeps last row's flags from satisfying the wait below.
        ST_CLEAR:      state <= ST_WAIT_FLAGS;
        ST_WAIT_FLAGS: if (&cb.flag_vec) begin
          snap  <= cb.node_center_bus;
          col   <= '0;
          state <= capture_en ? ST_CAPTURE : ST_NEXT;
        end
        ST_CAPTURE:    if (cb.pix_ready) begin
          if (last_col) begin
            col   <= '0;
            state <= ST_NEXT;
          end else begin
            col <= col + 1'b1;
          end
        end
        ST_NEXT: begin
          row_idx     <= wrap ? 8'd0 : row_idx + 8'd1;
          sweep_count <= next_count;
          sweep_done  <= wrap;
          if ((iter_limit != '0) && (next_count == iter_limit))
            state <= ST_DONE;
          else if (!run)
            state <= ST_IDLE;
          else
            state <= ST_START;
        end
        ST_DONE:       if (!run) state <= ST_IDLE;
        default:       state <= ST_IDLE;
      endcase
    end
  end
endmodule
